// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module   : memory_pkg
// Purpose  : Shared types and constants for the multi-cycle data memory
//            responder: FSM state encoding, default sizing and a helper that
//            derives the word-index width from the memory depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int c_default_latency     = 50;
  localparam int c_default_depth_words = 16384;

  // Word-index width for a power-of-two depth; never narrower than one bit.
  function automatic int idx_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

  localparam int c_default_idx_width = idx_width(c_default_depth_words);

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Load/store request/response bus between a CPU data port
//            (master) and the memory responder (slave).
// Signals  : is_input_valid - request valid
//            addr           - byte address, bits [1:0] ignored
//            mem_read       - request is a read
//            mem_write      - request is a write
//            din            - write data
//            mem_ready      - responder can accept a request this cycle
//            is_output_valid- one-cycle response pulse
//            dout           - read data, qualified by is_output_valid
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  is_input_valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] din;
  logic                  mem_ready;
  logic                  is_output_valid;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output is_input_valid,
    output addr,
    output mem_read,
    output mem_write,
    output din,
    input  mem_ready,
    input  is_output_valid,
    input  dout
  );

  modport slave (
    input  is_input_valid,
    input  addr,
    input  mem_read,
    input  mem_write,
    input  din,
    output mem_ready,
    output is_output_valid,
    output dout
  );

endinterface

`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
// ============================================================================
// Module   : mem_array
// Purpose  : Synchronous single-port word array with read-before-write.
//            When en is high the addressed word is captured into rdata and,
//            if we is also high, overwritten on the same edge; rdata thus
//            always carries the pre-write contents. rdata holds otherwise.
//            The storage itself is never cleared by reset.
// Ports    : clk, reset (async, active-low; clears rdata only),
//            en, we, idx (word index), wdata, rdata
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = c_default_depth_words,
  parameter int IDX_WIDTH   = idx_width(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      r_mem[idx] <= wdata;
    end
  end

  // Read port register: samples the old word on the same edge as a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= r_mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Fixed-latency word-addressed data memory acting as the responder
//            on the CPU load/store bus. One request is accepted in IDLE, held
//            for LATENCY rising edges in BUSY, then answered with a one-cycle
//            RESP pulse. Reads return the word as it was when RESP is entered;
//            writes commit on the edge that enters RESP and also return the
//            old word (read-before-write).
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-low
//            bus   - mem_responder_if slave modport (request/response)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = c_default_depth_words,
  parameter int LATENCY     = c_default_latency
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int c_idx_w = idx_width(DEPTH_WORDS);
  localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_idx_w-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_read;
  logic                  r_write;
  logic                  r_ready;
  logic                  r_out_valid;

  logic                  w_accept;
  logic                  w_commit;
  logic [c_idx_w-1:0]    w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_addr_unused;

  // Word index: drop the byte offset, wrap modulo the power-of-two depth.
  assign w_idx         = bus.addr[c_idx_w+1:2];
  assign w_addr_unused = ^bus.addr;

  // A request with neither flag set is not a request at all.
  assign w_accept = (r_state == IDLE) && bus.is_input_valid &&
                    (bus.mem_read || bus.mem_write);

  // The array is touched exactly once per request, on the edge entering RESP.
  // A reset before that edge therefore discards the pending write.
  assign w_commit = (r_state == BUSY) && (r_count == '0);

  mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_WIDTH   (c_idx_w)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (w_commit && (r_read || r_write)),
    .we    (w_commit && r_write),
    .idx   (r_idx),
    .wdata (r_din),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_din       <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_din   <= bus.din;
            r_read  <= bus.mem_read;
            r_write <= bus.mem_write;
            r_count <= c_cnt_load;
            r_ready <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // Counter starts at LATENCY-1, so RESP lands LATENCY edges after accept.
          if (r_count == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        RESP: begin
          r_out_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_ready       = r_ready;
  assign bus.is_output_valid = r_out_valid;
  // Array read register holds between responses, giving the hold behaviour.
  assign bus.dout            = w_rdata;

endmodule

`default_nettype wire
